// File: rtl/demux1_2_pipe_pkg.sv
// Shared constants for the registered 1:2 demux.
// The optional delivery counters are enabled by defining DEMUX_CNT_EN.
package demux1_2_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  localparam logic SEL_OUT1 = 1'b0;
  localparam logic SEL_OUT2 = 1'b1;

  // A slot can take a new word when empty or when its word leaves this cycle.
  function automatic logic slot_can_load(input logic valid, input logic ready);
    return ~valid | ready;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// Single-entry output register stage with load/drain handshake.
// Delivery counter present only when DEMUX_CNT_EN is defined.
module demux_out_slot
  import demux1_2_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef DEMUX_CNT_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_can_load,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] o_cnt
`endif
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_deliver;

  assign w_deliver  = r_valid & i_ready;
  assign o_can_load = slot_can_load(r_valid, i_ready);
  assign o_valid    = r_valid;
  assign o_data     = r_data;

  // A load wins over a drain: the new word replaces the departing one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (w_deliver) begin
      r_valid <= 1'b0;
    end
  end

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_deliver) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/demux1_2_pipe.sv
// Registered 1-to-2 demultiplexer with valid/ready on every port.
// Define DEMUX_CNT_EN to add per-output delivery counters oCnt1/oCnt2.
module demux1_2_pipe
  import demux1_2_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef DEMUX_CNT_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iData,
  input  logic              iSel,
  output logic              oValid1,
  output logic [DATA_W-1:0] oData1,
  input  logic              iReady1,
  output logic              oValid2,
  output logic [DATA_W-1:0] oData2,
  input  logic              iReady2
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] oCnt1
  , output logic [CNT_W-1:0] oCnt2
`endif
);

  logic w_can_load1;
  logic w_can_load2;
  logic w_accept;
  logic w_load1;
  logic w_load2;

  // Head-of-line: only the selected slot's readiness matters.
  assign oReady   = (iSel == SEL_OUT2) ? w_can_load2 : w_can_load1;
  assign w_accept = iValid & oReady;
  assign w_load1  = w_accept & (iSel == SEL_OUT1);
  assign w_load2  = w_accept & (iSel == SEL_OUT2);

  demux_out_slot #(
    .DATA_W (DATA_W)
`ifdef DEMUX_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load1),
    .i_data     (iData),
    .i_ready    (iReady1),
    .o_can_load (w_can_load1),
    .o_valid    (oValid1),
    .o_data     (oData1)
`ifdef DEMUX_CNT_EN
    , .o_cnt    (oCnt1)
`endif
  );

  demux_out_slot #(
    .DATA_W (DATA_W)
`ifdef DEMUX_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) u_slot2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load2),
    .i_data     (iData),
    .i_ready    (iReady2),
    .o_can_load (w_can_load2),
    .o_valid    (oValid2),
    .o_data     (oData2)
`ifdef DEMUX_CNT_EN
    , .o_cnt    (oCnt2)
`endif
  );

endmodule

// File: doc/demux1_2_pipe.md
Name: demux1_2_pipe

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshake on every port.
- Steers a 32-bit data stream from one producer to one of two consumers, chosen per transfer by a select bit.
- Write-side counterpart of the datapath 2:1 mux. Used where one result must be routed to two downstream pipeline consumers, e.g. writeback vs. store path.
- One register stage per output; full throughput when consumers are ready.

Parameters:
- DATA_W, 32, width of the data path.
- CNT_W, 16, width of the per-output transfer counters; only used when DEMUX_CNT_EN is defined.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- iValid  input  1  producer has a word on iData.
- oReady  output  1  demux accepts the word this cycle.
- iData  input  DATA_W  input word.
- iSel  input  1  destination: 0 routes to output 1, 1 routes to output 2.
- oValid1  output  1  output 1 holds a word.
- oData1  output  DATA_W  output 1 word.
- iReady1  input  1  consumer 1 takes the word this cycle.
- oValid2  output  1  output 2 holds a word.
- oData2  output  DATA_W  output 2 word.
- iReady2  input  1  consumer 2 takes the word this cycle.
- oCnt1  output  CNT_W  words delivered on output 1 (DEMUX_CNT_EN only).
- oCnt2  output  CNT_W  words delivered on output 2 (DEMUX_CNT_EN only).

Behaviour:
- Reset, asynchronous while rst_n=0:
  - oValid1=0, oValid2=0, oData1=0, oData2=0, counters 0.
  - Any held words are discarded.
  - A reset asserted mid-transfer drops the word; it is not replayed.
- Each output k has one slot holding valid_k and data_k. oValidk=valid_k and oDatak=data_k come straight from flops.
- Slot k can load when valid_k=0, or when valid_k=1 and iReadyk=1 (drained this cycle).
- oReady is combinational: it equals the can-load signal of slot 1 when iSel=0, and of slot 2 when iSel=1. It does not depend on iValid.
- Accept occurs when iValid=1 and oReady=1. On the next edge, slot[iSel] loads iData and sets valid.
- Drain occurs when valid_k=1 and iReadyk=1 with no load into k. valid_k clears on the next edge.
- Load and drain of the same slot in one cycle: the new word replaces the old one and valid stays 1. This sustains 1 word/cycle.
- The non-selected slot drains independently in the same cycle.
- Latency: 1 cycle from accept to oValidk=1.
- Producer rules: while iValid=1 and oReady=0, iData and iSel must stay stable. iValid must not drop before acceptance.
- Consumer rules: oDatak is stable while oValidk=1 and iReadyk=0.
- Ordering:
  - Order is preserved within each output.
  - There is no ordering guarantee across the two outputs.
- Head-of-line: a stalled selected output blocks input, even if the other output is free.

Optional Feature:
- Macro DEMUX_CNT_EN.
- Defined:
  - oCnt1/oCnt2 increment by 1 on each completed output handshake (oValidk & iReadyk).
  - They wrap modulo 2^CNT_W (0xFFFF -> 0x0000) and reset to 0.
- Undefined: oCnt1/oCnt2 ports and counter logic are absent.

Decomposition:
- Shared package holds DATA_W default 32, CNT_W default 16, and named constants SEL_OUT1=1'b0 and SEL_OUT2=1'b1.
- One natural sub-module, demux_out_slot: single-entry register stage with load/drain handshake and the optional counter. It is instantiated twice.
- Top level holds the select decode and oReady mux.

Test Plan:
- Reset: hold rst_n=0 with iValid=1, iData=0xDEADBEEF -> oValid1=oValid2=0, oData1=oData2=0, oCnt=0. After release, the first accept appears 1 cycle later.
- Streaming: iReady1=1, send 0x1,0x2,0x3 with iSel=0 on consecutive cycles -> oReady stays 1; oData1 shows 0x1,0x2,0x3 on the next three cycles; oValid2 stays 0.
- Backpressure: iReady1=0, send 0xA (iSel=0) then 0xB (iSel=0) -> oReady=0 on 0xB. 0xA is held; after iReady1=1, 0xB follows with no loss or duplication.
- Independent outputs: iReady1=0, slot1 full, present 0x55 with iSel=1 and iReady2=1 -> accepted immediately; oData2=0x55 next cycle; slot1 unchanged.
- Mid-operation reset: both slots full (0x11, 0x22), rst_n pulses low asynchronously between edges -> oValid1=oValid2=0 at once; the words are never delivered.
- DEMUX_CNT_EN: preload via 0xFFFF deliveries on output 2, then one more -> oCnt2 reads 0x0000 and oCnt1 is unaffected.
